// File: rtl/uart_tx_mmio_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_tx_mmio_pkg : shared state encoding, STATUS layout, register offsets |
// | Optional feature macro: UART_TX_PARITY_EN                                 |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_tx_mmio_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
    localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

    localparam int STAT_FULL    = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 3;
    localparam int STAT_CNT_W   = 4;

endpackage

`default_nettype wire

// File: rtl/uart_tx_mmio_sync_fifo.sv
// +--------------------------------------------------------------------------+
// | sync_fifo : single-clock first-word-fall-through FIFO, power-of-two depth |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is refused even when a pop frees a slot this cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// +--------------------------------------------------------------------------+
// | uart_tx_mmio : memory-mapped 8N1 UART transmitter with transmit FIFO      |
// | Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit)       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] Read_data,
    output logic        tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic          pop;
    logic          sel_tx;
    logic          sel_st;
    logic          store;
    logic          ovf_event;
    logic          overflow;
    logic          busy;
    logic          baud_end;
    logic [3:0]    count_lo;
    logic [31:0]   status;
    logic          unused_bits;

    uart_state_t   state;
    logic [15:0]   baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    assign sel_tx      = (Address == (BASE_ADDR + TXDATA_OFS));
    assign sel_st      = (Address == (BASE_ADDR + STATUS_OFS));
    assign store       = MemWrite && sel_tx && !reset;
    assign ovf_event   = store && fifo_full;
    assign busy        = !fifo_empty || (state != ST_IDLE);
    assign baud_end    = (baud == 16'(CLKS_PER_BIT - 1));
    assign count_lo    = 4'(fifo_count);
    assign unused_bits = ^Write_data[31:8];

    // The head is taken either from idle or at the last stop-bit cycle, so frames chain without a gap.
    assign pop = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && baud_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (store),
        .pop   (pop),
        .din   (Write_data[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                               = '0;
        status[STAT_FULL]                    = fifo_full;
        status[STAT_BUSY]                    = busy;
        status[STAT_OVF]                     = overflow;
        status[STAT_CNT_LSB +: STAT_CNT_W]   = count_lo;
        Read_data                            = sel_st ? status : '0;
    end

    // A new overflow outranks the read-to-clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (ovf_event) begin
            overflow <= 1'b1;
        end else if (MemRead && sel_st) begin
            overflow <= 1'b0;
        end
    end

    // tx is registered from the current state, so it trails the state by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            tx      <= 1'b1;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx      <= 1'b1;
                    baud    <= '0;
                    bit_idx <= '0;
                    if (!fifo_empty) begin
                        shreg <= fifo_dout;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    tx <= 1'b0;
                    if (baud_end) begin
                        baud  <= '0;
                        state <= ST_DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    tx <= shreg[bit_idx];
                    if (baud_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= ST_PARITY;
`else
                            state   <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    tx <= ^shreg;
                    if (baud_end) begin
                        baud  <= '0;
                        state <= ST_STOP;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud <= '0;
                        if (!fifo_empty) begin
                            shreg <= fifo_dout;
                            state <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    baud  <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
// +--------------------------------------------------------------------------+
// | tb_uart_tx_mmio : scoreboard bench for uart_tx_mmio (CLKS_PER_BIT=4)      |
// | Honours UART_TX_PARITY_EN for the parity frame checks                     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_mmio;

    localparam int          CLKS  = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h4000_0018;
    localparam logic [31:0] STAT  = 32'h4000_001C;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CLKS;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Read_data;
    logic        tx;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic        mon_en;
    int          exp_q[$];
    int          start_q[$];
    logic [3:0]  cnt_seq[$];

    logic [7:0]  mon_d;
    logic        mon_p;
    int          mon_e;

    uart_tx_mmio #(
        .CLKS_PER_BIT (CLKS),
        .FIFO_DEPTH   (DEPTH),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .Read_data  (Read_data),
        .tx         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100us;
        $display("FAIL watchdog: simulation time limit reached, got hang want finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int start_at(input int k);
        return (k < start_q.size()) ? start_q[k] : -100000;
    endfunction

    task automatic bus_write(input logic [7:0] d, input bit accepted, input bit with_read);
        @(negedge clk);
        Address    = BASE;
        Write_data = {24'h5A5A5A, d};
        MemWrite   = 1'b1;
        MemRead    = with_read;
        if (accepted) exp_q.push_back(int'(d));
    endtask

    task automatic bus_idle();
        @(negedge clk);
        Address  = STAT;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
    endtask

    task automatic read_status(output logic [31:0] v);
        @(negedge clk);
        Address  = STAT;
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        #1 v = Read_data;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int n = 0; n < max_cyc; n++) begin
            bus_idle();
            #1;
            if (!Read_data[1]) break;
        end
        check_eq("idle_reached", 32'(Read_data[1]), 32'd0);
        repeat (4) bus_idle();
    endtask

    // Serial receiver: samples each bit near its centre and scores the decoded byte.
    always begin
        @(negedge clk);
        if (mon_en && tx === 1'b0) begin
            start_q.push_back(cyc);
            repeat (CLKS / 2) @(negedge clk);
            check_eq("rx_start", 32'(tx), 32'd0);
            for (int b = 0; b < 8; b++) begin
                repeat (CLKS) @(negedge clk);
                mon_d[b] = tx;
            end
`ifdef UART_TX_PARITY_EN
            repeat (CLKS) @(negedge clk);
            mon_p = tx;
`else
            mon_p = 1'b0;
`endif
            repeat (CLKS) @(negedge clk);
            check_eq("rx_stop", 32'(tx), 32'd1);
            mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h1FF;
            check_eq("rx_byte", 32'(mon_d), mon_e);
`ifdef UART_TX_PARITY_EN
            check_eq("rx_parity", 32'(mon_p), 32'(^mon_e[7:0]));
`endif
        end
    end

    initial begin : main
        logic [31:0] v;
        logic [7:0]  a5;
        int          lows;
        int          last_cnt;
        logic        exp_bit;

        reset      = 1'b1;
        Address    = STAT;
        Write_data = '0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        mon_en     = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_tx", 32'(tx), 32'd1);
        check_eq("reset_status", Read_data, 32'd0);
        reset = 1'b0;
        repeat (2) bus_idle();

        // Single A5 frame, checked cycle by cycle.
        a5 = 8'hA5;
        bus_write(a5, 1'b1, 1'b0);
        bus_idle();
        check_eq("lat0_tx", 32'(tx), 32'd1);
        bus_idle();
        check_eq("lat1_tx", 32'(tx), 32'd1);
        for (int i = 0; i < FRAME_CYC; i++) begin
            bus_idle();
            if (i / CLKS == 0)                 exp_bit = 1'b0;
            else if (i / CLKS <= 8)            exp_bit = a5[i / CLKS - 1];
`ifdef UART_TX_PARITY_EN
            else if (i / CLKS == 9)            exp_bit = ^a5;
`endif
            else                               exp_bit = 1'b1;
            check_eq($sformatf("a5_tx[%0d]", i), 32'(tx), 32'(exp_bit));
            if (i < 9 * CLKS) check_eq($sformatf("a5_busy[%0d]", i), 32'(Read_data[1]), 32'd1);
        end
        wait_idle(20);
        check_eq("a5_status_after", Read_data, 32'd0);

        // Three queued bytes behind a running frame: count drains 3,2,1,0 with no gaps.
        start_q.delete();
        bus_write(8'hFF, 1'b1, 1'b0);
        repeat (5) bus_idle();
        bus_write(8'h01, 1'b1, 1'b0);
        bus_write(8'h02, 1'b1, 1'b0);
        bus_write(8'h03, 1'b1, 1'b0);
        last_cnt = -1;
        cnt_seq.delete();
        for (int n = 0; n < 400; n++) begin
            bus_idle();
            #1;
            if (int'(Read_data[6:3]) != last_cnt) cnt_seq.push_back(Read_data[6:3]);
            last_cnt = int'(Read_data[6:3]);
            if (!Read_data[1]) break;
        end
        check_eq("cnt_seq_len", cnt_seq.size(), 32'd4);
        for (int k = 0; k < 4; k++)
            check_eq($sformatf("cnt_seq[%0d]", k),
                     (k < cnt_seq.size()) ? 32'(cnt_seq[k]) : 32'hFFFF, 32'(3 - k));
        repeat (4) bus_idle();
        check_eq("b2b_frames", start_q.size(), 32'd4);
        for (int k = 0; k < 3; k++)
            check_eq($sformatf("b2b_gap[%0d]", k), start_at(k + 1) - start_at(k), FRAME_CYC);
        check_eq("b2b_span", start_at(3) - start_at(1) + FRAME_CYC, 3 * FRAME_CYC);

        // Overflow: first byte pops at once, four fill the FIFO, sixth is dropped.
        for (int k = 0; k < 6; k++) bus_write(8'h10 + 8'(k), k < 5, 1'b0);
        read_status(v);
        check_eq("ovf_status", v, 32'h27);
        read_status(v);
        check_eq("ovf_cleared", v, 32'h23);
        bus_write(8'h20, 1'b0, 1'b1);
        #1 check_eq("txdata_reads0", Read_data, 32'd0);
        read_status(v);
        check_eq("ovf_with_load", v, 32'h27);
        read_status(v);
        check_eq("ovf_cleared2", v, 32'h23);
        @(negedge clk);
        Address = BASE + 32'd8;
        MemRead = 1'b1;
        #1 check_eq("unmapped_reads0", Read_data, 32'd0);
        wait_idle(6 * FRAME_CYC + 50);

        // Reset in the middle of DATA, with a store held during the reset cycle.
        mon_en = 1'b0;
        bus_write(8'h3C, 1'b0, 1'b0);
        repeat (16) bus_idle();
        @(negedge clk);
        reset      = 1'b1;
        Address    = BASE;
        Write_data = 32'h55;
        MemWrite   = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        MemWrite = 1'b0;
        Address  = STAT;
        #1;
        check_eq("rst_mid_tx", 32'(tx), 32'd1);
        check_eq("rst_mid_status", Read_data, 32'd0);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check_eq("rst_no_frame", lows, 32'd0);
        check_eq("rst_store_ignored", Read_data, 32'd0);
        mon_en = 1'b1;

`ifdef UART_TX_PARITY_EN
        start_q.delete();
        bus_write(8'h07, 1'b1, 1'b0);
        bus_write(8'h03, 1'b1, 1'b0);
        wait_idle(3 * FRAME_CYC + 20);
        check_eq("par_frames", start_q.size(), 32'd2);
        check_eq("par_frame_len", start_at(1) - start_at(0), 11 * CLKS);
`endif

        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
